// File: rtl/move_engine_if.sv
// Signal bundle for move_engine: card loading, move handshake, completion status
// and the registered read-back port.
interface move_engine_if;
    logic       load_valid;
    logic [3:0] load_pile;
    logic [6:0] load_card;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_src;
    logic [3:0] move_dst;
    logic [4:0] move_offset;
    logic       done;
    logic       ok;
    logic [2:0] err;
    logic [3:0] rd_pile;
    logic [4:0] rd_idx;
    logic [6:0] rd_card;
    logic [5:0] rd_count;

    modport master (
        output load_valid, load_pile, load_card,
        output move_valid, move_src, move_dst, move_offset,
        output rd_pile, rd_idx,
        input  move_ready, done, ok, err, rd_card, rd_count
    );

    modport slave (
        input  load_valid, load_pile, load_card,
        input  move_valid, move_src, move_dst, move_offset,
        input  rd_pile, rd_idx,
        output move_ready, done, ok, err, rd_card, rd_count
    );
endinterface

// File: rtl/move_engine.sv
// Solitaire tableau move engine: validates a run move between piles (or to a
// foundation), transfers it one card per cycle and flips the newly exposed card.
module move_engine #(
    parameter int NUM_PILES = 7,
    parameter int DEPTH     = 19
) (
    input  logic         clk,
    input  logic         rst,
    move_engine_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MOVE, S_FLIP, S_DONE} state_t;

    localparam logic [3:0] NP      = 4'(NUM_PILES);
    localparam logic [5:0] DEPTH_C = 6'(DEPTH);
    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    // Storage is sized to the full index range so pile/slot numbers index it directly;
    // entries beyond NUM_PILES/DEPTH are never written and stay constant zero.
    logic [6:0] slot [16][32];
    logic [5:0] cnt  [16];
    logic [3:0] fnd  [4];

    state_t     state, state_nx;
    logic [3:0] src_p0, dst_p0;
    logic [4:0] off_p0;
    logic [4:0] base_p0;
    logic [4:0] k_p0;
    logic [2:0] code_p0;
    logic       done_r, ok_r;
    logic [2:0] err_r;
    logic [6:0] rd_card_r;
    logic [5:0] rd_count_r;

    logic       move_ready;
    logic       accept;
    logic       load_ok;
    logic [5:0] src_cnt, dst_cnt;
    logic [4:0] sel_idx, dst_top_idx, mv_idx;
    logic [6:0] sel_card, mv_card;
    logic [3:0] sel_rank;
    logic [1:0] sel_suit;
    logic [2:0] chk_code;

    assign move_ready = (state == S_IDLE) && !rst;
    assign accept     = bus.move_valid && move_ready;
    assign load_ok    = bus.load_valid && !accept && (bus.load_pile != 4'd0) &&
                        (bus.load_pile <= NP) && (cnt[bus.load_pile] < DEPTH_C);

    // Move legality, evaluated from the captured request and current storage
    always_comb begin
        src_cnt     = cnt[src_p0];
        dst_cnt     = cnt[dst_p0];
        sel_idx     = 5'(src_cnt - 6'd1 - {1'b0, off_p0});
        dst_top_idx = 5'(dst_cnt - 6'd1);
        sel_card    = slot[src_p0][sel_idx];
        sel_rank    = sel_card[6:3];
        sel_suit    = sel_card[2:1];
        mv_idx      = base_p0 + k_p0;
        mv_card     = slot[src_p0][mv_idx];
        chk_code    = 3'd0;
        if (src_p0 == 4'd0 || src_p0 > NP || dst_p0 > NP || src_p0 == dst_p0)
            chk_code = 3'd1;
        else if ({1'b0, off_p0} >= src_cnt || !sel_card[0])
            chk_code = 3'd2;
        else if (dst_p0 != 4'd0 && ({1'b0, dst_cnt} + {2'b0, off_p0} + 7'd1) > DEPTH_W)
            chk_code = 3'd4;
        else if (dst_p0 == 4'd0)
            chk_code = (off_p0 == 5'd0 &&
                        {1'b0, sel_rank} == {1'b0, fnd[sel_suit]} + 5'd1) ? 3'd0 : 3'd3;
        else if (dst_cnt == 6'd0)
            chk_code = (sel_rank == 4'd13) ? 3'd0 : 3'd3;
        else
            chk_code = (slot[dst_p0][dst_top_idx][2] != sel_card[2] &&
                        {1'b0, slot[dst_p0][dst_top_idx][6:3]} == {1'b0, sel_rank} + 5'd1)
                       ? 3'd0 : 3'd3;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CHECK;
            S_CHECK: state_nx = (chk_code == 3'd0) ? S_MOVE : S_DONE;
            S_MOVE:  if (k_p0 == off_p0) state_nx = S_FLIP;
            S_FLIP:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '{default: '0};
            cnt        <= '{default: '0};
            fnd        <= '{default: '0};
            src_p0     <= '0;
            dst_p0     <= '0;
            off_p0     <= '0;
            base_p0    <= '0;
            k_p0       <= '0;
            code_p0    <= '0;
            done_r     <= 1'b0;
            ok_r       <= 1'b0;
            err_r      <= '0;
            rd_card_r  <= '0;
            rd_count_r <= '0;
        end else begin
            done_r <= (state == S_DONE);
            if (state == S_DONE) begin
                ok_r  <= (code_p0 == 3'd0);
                err_r <= code_p0;
            end
            rd_card_r  <= (bus.rd_pile != 4'd0 && bus.rd_pile <= NP &&
                           {1'b0, bus.rd_idx} < cnt[bus.rd_pile]) ? slot[bus.rd_pile][bus.rd_idx] : 7'd0;
            rd_count_r <= (bus.rd_pile != 4'd0 && bus.rd_pile <= NP) ? cnt[bus.rd_pile] : 6'd0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        src_p0 <= bus.move_src;
                        dst_p0 <= bus.move_dst;
                        off_p0 <= bus.move_offset;
                    end else if (load_ok) begin
                        slot[bus.load_pile][5'(cnt[bus.load_pile])] <= bus.load_card;
                        cnt[bus.load_pile] <= cnt[bus.load_pile] + 6'd1;
                    end
                end
                S_CHECK: begin
                    code_p0 <= chk_code;
                    base_p0 <= sel_idx;
                    k_p0    <= '0;
                end
                S_MOVE: begin
                    // Bottom of the run goes first so the destination keeps run order
                    if (dst_p0 == 4'd0) begin
                        fnd[mv_card[2:1]] <= fnd[mv_card[2:1]] + 4'd1;
                    end else begin
                        slot[dst_p0][5'(cnt[dst_p0])] <= mv_card;
                        cnt[dst_p0] <= cnt[dst_p0] + 6'd1;
                    end
                    slot[src_p0][mv_idx] <= 7'd0;
                    k_p0 <= k_p0 + 5'd1;
                    if (k_p0 == off_p0) cnt[src_p0] <= {1'b0, base_p0};
                end
                S_FLIP: begin
                    if (cnt[src_p0] != 6'd0) slot[src_p0][5'(cnt[src_p0] - 6'd1)][0] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.move_ready = move_ready;
    assign bus.done       = done_r;
    assign bus.ok         = ok_r;
    assign bus.err        = err_r;
    assign bus.rd_card    = rd_card_r;
    assign bus.rd_count   = rd_count_r;
endmodule

// File: tb/tb_move_engine.sv
// Self-checking bench for move_engine: directed scenarios plus randomized loads/moves
// compared against an array-based model of piles and foundations.
module tb_move_engine;
    localparam int NP = 7;
    localparam int DP = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_engine_if bus ();
    move_engine_if bus4 ();

    move_engine #(.NUM_PILES(NP), .DEPTH(DP)) dut  (.clk(clk), .rst(rst), .bus(bus));
    move_engine #(.NUM_PILES(NP), .DEPTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [6:0] mcard [16][32];
    int         msz   [16];
    int         mfnd  [4];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < 16; p++) begin
            msz[p] = 0;
            for (int i = 0; i < 32; i++) mcard[p][i] = 7'd0;
        end
        for (int s = 0; s < 4; s++) mfnd[s] = 0;
    endtask

    function automatic int model_err(input int src, input int dst, input int off);
        logic [6:0] c, t;
        if (src < 1 || src > NP || dst < 0 || dst > NP || src == dst) return 1;
        if (off >= msz[src]) return 2;
        c = mcard[src][msz[src] - 1 - off];
        if (c[0] == 1'b0) return 2;
        if (dst != 0 && msz[dst] + off + 1 > DP) return 4;
        if (dst == 0) return (off == 0 && int'(c[6:3]) == mfnd[c[2:1]] + 1) ? 0 : 3;
        if (msz[dst] == 0) return (c[6:3] == 4'd13) ? 0 : 3;
        t = mcard[dst][msz[dst] - 1];
        return (t[2] != c[2] && int'(t[6:3]) == int'(c[6:3]) + 1) ? 0 : 3;
    endfunction

    task automatic model_apply(input int src, input int dst, input int off);
        int base;
        logic [6:0] c;
        base = msz[src] - 1 - off;
        for (int i = 0; i <= off; i++) begin
            c = mcard[src][base + i];
            if (dst == 0) mfnd[c[2:1]]++;
            else begin
                mcard[dst][msz[dst]] = c;
                msz[dst]++;
            end
            mcard[src][base + i] = 7'd0;
        end
        msz[src] = base;
        if (base > 0) mcard[src][base - 1][0] = 1'b1;
    endtask

    task automatic load(input int p, input logic [6:0] c);
        bus.load_valid = 1'b1;
        bus.load_pile  = 4'(p);
        bus.load_card  = c;
        @(negedge clk);
        bus.load_valid = 1'b0;
        if (p >= 1 && p <= NP && msz[p] < DP) begin
            mcard[p][msz[p]] = c;
            msz[p]++;
        end
    endtask

    task automatic verify(input string tag);
        logic [6:0] e;
        for (int p = 1; p <= NP + 1; p++) begin
            for (int i = 0; i < DP; i++) begin
                bus.rd_pile = 4'(p);
                bus.rd_idx  = 5'(i);
                @(negedge clk);
                if (i == 0) chk($sformatf("%s_cnt_p%0d", tag, p), 32'(bus.rd_count), (p <= NP) ? msz[p] : 0);
                e = (p <= NP && i < msz[p]) ? mcard[p][i] : 7'd0;
                chk($sformatf("%s_card_p%0d_i%0d", tag, p, i), 32'(bus.rd_card), 32'(e));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.move_ready), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ok", 32'(bus.ok), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst_ready_after", 32'(bus.move_ready), 1);
        @(negedge clk);
    endtask

    task automatic do_move(input string tag, input int src, input int dst, input int off, input bit with_load);
        int  exp_err, n;
        bit  seen;
        exp_err = model_err(src, dst, off);
        n = 0;
        while (!bus.move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.move_ready), 1);
        bus.move_valid  = 1'b1;
        bus.move_src    = 4'(src);
        bus.move_dst    = 4'(dst);
        bus.move_offset = 5'(off);
        if (with_load) begin
            bus.load_valid = 1'b1;
            bus.load_pile  = 4'd3;
            bus.load_card  = 7'h11;
        end
        @(posedge clk);
        #1;
        bus.move_valid = 1'b0;
        bus.load_valid = 1'b0;
        if (exp_err == 0) model_apply(src, dst, off);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.done;
        end
        chk({tag, "_done"}, 32'(seen), 1);
        chk({tag, "_latency"}, n, (exp_err == 0) ? off + 4 : 2);
        chk({tag, "_ok"}, 32'(bus.ok), (exp_err == 0) ? 1 : 0);
        chk({tag, "_err"}, 32'(bus.err), exp_err);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.done), 0);
        chk({tag, "_err_hold"}, 32'(bus.err), exp_err);
        @(negedge clk);
        verify(tag);
    endtask

    function automatic logic [6:0] rand_card();
        logic [3:0] r;
        logic [1:0] s;
        logic       u;
        r = 4'($urandom_range(1, 13));
        s = 2'($urandom_range(0, 3));
        u = ($urandom_range(0, 3) != 0);
        return {r, s, u};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_valid = 0; bus.load_pile = 0; bus.load_card = 0;
        bus.move_valid = 0; bus.move_src = 0; bus.move_dst = 0; bus.move_offset = 0;
        bus.rd_pile = 0; bus.rd_idx = 0;
        bus4.load_valid = 0; bus4.load_pile = 0; bus4.load_card = 0;
        bus4.move_valid = 0; bus4.move_src = 0; bus4.move_dst = 0; bus4.move_offset = 0;
        bus4.rd_pile = 0; bus4.rd_idx = 0;
        @(negedge clk);

        do_reset();
        verify("reset");

        // 7H onto 8S, exposing a face-down 5C that must flip
        load(1, 7'h28); load(1, 7'h3D); load(2, 7'h43);
        do_move("flip", 1, 2, 0, 0);

        do_reset();
        load(1, 7'h3D); load(2, 7'h39);
        do_move("rule", 1, 2, 0, 0);

        do_reset();
        load(3, 7'h6B);
        do_move("king_empty", 3, 4, 0, 0);
        load(5, 7'h65);
        do_move("queen_on_king", 5, 4, 0, 0);

        do_reset();
        load(1, 7'h09);
        do_move("ace_fnd", 1, 0, 0, 0);
        load(1, 7'h0D); load(1, 7'h13);
        do_move("fnd_offset", 1, 0, 1, 0);
        do_move("bad_src", 9, 2, 0, 0);
        do_move("same_pile", 2, 2, 0, 0);
        load(2, 7'h11);
        do_move("two_fnd", 2, 0, 0, 0);
        load(3, 7'h28);
        do_move("face_down", 3, 4, 0, 0);
        do_move("off_range", 1, 4, 5, 0);

        do_reset();
        for (int i = 0; i < 17; i++) load(4, 7'h28);
        load(4, 7'h43);
        load(5, 7'h3D); load(5, 7'h33);
        do_move("overflow", 5, 4, 1, 0);
        load(6, 7'h6B);
        do_move("run_to_empty", 5, 7, 1, 0);

        // Reset during the second transfer cycle of a three-card run
        do_reset();
        load(1, 7'h6B); load(1, 7'h65); load(1, 7'h59);
        chk("mid_ready", 32'(bus.move_ready), 1);
        bus.move_valid = 1'b1; bus.move_src = 4'd1; bus.move_dst = 4'd2; bus.move_offset = 5'd2;
        @(posedge clk);
        #1;
        bus.move_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done", 32'(bus.done), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ready_in_rst", 32'(bus.move_ready), 0);
        rst = 1'b0;
        model_clear();
        #1;
        chk("mid_ready_after", 32'(bus.move_ready), 1);
        repeat (6) begin
            @(negedge clk);
            chk("mid_no_done_after", 32'(bus.done), 0);
        end
        verify("mid_rst");

        do_reset();
        load(1, 7'h6B);
        do_move("move_wins", 1, 2, 0, 1);

        for (int i = 0; i < 5; i++) begin
            bus4.load_valid = 1'b1;
            bus4.load_pile  = 4'd1;
            bus4.load_card  = 7'(8'h09 + 8'(i * 8));
            @(negedge clk);
        end
        bus4.load_valid = 1'b0;
        bus4.rd_pile = 4'd1;
        bus4.rd_idx  = 5'd3;
        @(negedge clk);
        chk("full_count", 32'(bus4.rd_count), 4);
        chk("full_top", 32'(bus4.rd_card), 32'h21);

        do_reset();
        for (int r = 0; r < 40; r++) begin
            int src, dst, off;
            repeat ($urandom_range(1, 3)) load($urandom_range(0, 8), rand_card());
            src = $urandom_range(0, 8);
            dst = $urandom_range(0, 8);
            off = $urandom_range(0, 2);
            do_move($sformatf("rnd%0d", r), src, dst, off, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
